inst_fetch_wide: RTL and testbench
==================================

// Module: inst_fetch_wide
// PURPOSE
//  Parametrised successor of the single/dual fetch stage: byte-serial program loader fills instruction
//  memory, then FETCH_WIDTH consecutive instructions per cycle go to decode, with stall and branch
//  redirect. Sits between the host program loader (UART side) and the decode stage.
// PARAMETERS
//  INST_MEM_WIDTH  10  address width in words; memory depth DEPTH = 2**INST_MEM_WIDTH
//  FETCH_WIDTH     2   instructions delivered per cycle (1..4); lane 0 = lowest pc
// PORTS
//  CLK           in   1                        clock, all logic on posedge
//  reset         in   1                        asynchronous, active-high
//  loader_data   in   8                        program byte
//  loader_valid  in   1                        loader_data valid this cycle
//  loader_start  in   1                        begin (re)load; discards current program
//  loader_end    in   1                        last byte already sent; finish load
//  loader_ready  out  1                        1 in IDLE/LOAD (bytes accepted), 0 in RUN
//  stall         in   1                        hold outputs and pc
//  redirect      in   1                        branch taken: next fetch from redirect_pc
//  redirect_pc   in   INST_MEM_WIDTH           redirect target (word index)
//  inst          out  FETCH_WIDTH x 32         fetched instructions
//  inst_valid    out  FETCH_WIDTH              per-lane valid
//  fetch_pc      out  INST_MEM_WIDTH           pc of lane 0 of current inst
//  pc_next       out  INST_MEM_WIDTH           pc of next fetch group
//  load_done     out  1                        program loaded, RUN state
//  load_err      out  1                        sticky: bytes dropped, memory overflow
// BEHAVIOUR
//  Reset: state IDLE; inst=0, inst_valid=0, fetch_pc=0, pc_next=0, load_done=0, load_err=0,
//   loader_ready=1; word count and byte counter 0. Memory contents not reset.
//  FSM IDLE->LOAD on loader_start; LOAD->RUN on loader_end; RUN->LOAD on loader_start (reload).
//  loader_start clears word count, byte counter, load_err, inst_valid, load_done in same edge.
//  LOAD: bytes packed big-endian (1st byte -> [31:24]); 4th byte writes word at address count,
//   count++. loader_valid and loader_end same cycle: byte taken first, then end processing.
//   End with 1..3 pending bytes: word zero-padded in low bytes and written, count++.
//   Count == DEPTH: further bytes dropped, load_err=1 (sticky until next loader_start).
//  RUN: entered with pc_next=0. Each unstalled cycle registers lane i = mem[(pc_next+i) mod DEPTH],
//   inst_valid[i] = ((pc_next+i) mod DEPTH) < count; fetch_pc<=pc_next; pc_next+=FETCH_WIDTH mod DEPTH.
//   Latency 1 cycle pc_next -> inst. Unaligned pc allowed; wrap-around at DEPTH-1 -> 0.
//  stall=1: inst, inst_valid, fetch_pc, pc_next hold.
//  redirect=1 (priority over stall): inst_valid<=0 next cycle, pc_next<=redirect_pc; fetch resumes
//   the cycle after. Redirect/stall ignored outside RUN.
//  count==0 at loader_end: RUN with all lanes invalid.
//  Reset mid-load: IDLE; partial word lost; memory keeps already written words but count=0.
// CONFIGURATION
//  INST_FETCH_CHECKSUM_EN defined: extra output load_checksum[31:0] = XOR of every word written in
//   the current load (incl. padded last word), cleared on reset/loader_start, stable in RUN.
//  Undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  inst_fetch_pkg: state enum {S_IDLE,S_LOAD,S_RUN}, INST_BITS=32, BYTES_PER_INST=4.
//  Sub-module inst_loader_pack: byte counter/shift register -> word + write strobe + pad on end.
//  Top holds FSM, memory array (multi-port read, registered outputs), pc logic.
// TESTING
//  1 Load 8 bytes 00 11 22 33 44 55 66 77, end; FETCH_WIDTH=2 -> first group inst={00112233,
//    44556677}, inst_valid=2'b11, fetch_pc=0; next group inst_valid=2'b00.
//  2 Load 5 bytes AA BB CC DD EE, end -> mem[1]=EE000000, count=2, lane1 valid at pc=0.
//  3 INST_MEM_WIDTH=2, load 20 bytes -> load_err=1, count=4; fetch at pc=3 gives lanes mem[3],mem[0].
//  4 RUN, stall 3 cycles -> outputs frozen; redirect=1 with stall=1, redirect_pc=5 -> inst_valid=0
//    next cycle, then fetch_pc=5.
//  5 Reset asserted mid-LOAD (after 6 bytes) async -> all outputs at reset values before next edge;
//    reload 4 bytes 01 02 03 04 -> mem[0]=01020304.
//  6 With INST_FETCH_CHECKSUM_EN: load 11223344, 55667788 -> load_checksum=444444CC; reload clears it.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the wide instruction fetch stage:
// FSM state encoding and instruction word geometry.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_e;

  localparam int INST_BITS      = 32;
  localparam int BYTES_PER_INST = 4;

endpackage

// File: rtl/inst_loader_pack.sv
// Byte-serial to word packer: big-endian accumulation, one write strobe per
// complete word, zero-padded flush of 1..3 pending bytes on end.
// Ports: clk/rst, clr_i (drop partial word), en_i (LOAD active), data_i,
// valid_i, end_i; word_o/we_o (memory write request).
module inst_loader_pack
  import inst_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [7:0]           data_i,
  input  logic                 valid_i,
  input  logic                 end_i,
  output logic [INST_BITS-1:0] word_o,
  output logic                 we_o
);

  logic [1:0]           cnt_q, cnt_d, cnt_b;
  logic [INST_BITS-1:0] acc_q, acc_d, acc_b;
  logic [4:0]           shamt;

  // first byte lands in [31:24]: shift = 8*(3-cnt) = {~cnt,3'b0}
  assign shamt = {~cnt_q, 3'b000};

  always_comb begin
    cnt_b  = cnt_q;
    acc_b  = acc_q;
    we_o   = 1'b0;
    word_o = acc_q;
    if (en_i && valid_i) begin
      acc_b = acc_q | ({24'b0, data_i} << shamt);
      cnt_b = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        we_o   = 1'b1;
        word_o = acc_b;
        acc_b  = '0;
      end
    end
    cnt_d = cnt_b;
    acc_d = acc_b;
    // byte of this cycle is already merged; flush any remainder
    if (en_i && end_i) begin
      if (cnt_b != 2'd0) begin
        we_o   = 1'b1;
        word_o = acc_b;
      end
      cnt_d = '0;
      acc_d = '0;
    end
    if (clr_i) begin
      cnt_d = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/inst_fetch_wide.sv
// Wide fetch stage: loads a program byte-serially into instruction memory,
// then delivers FETCH_WIDTH consecutive instructions per cycle to decode,
// with stall and branch redirect.
// Ports: CLK, reset; loader_* (host loader handshake); stall, redirect,
// redirect_pc; inst/inst_valid/fetch_pc/pc_next; load_done, load_err.
// Optional INST_FETCH_CHECKSUM_EN adds load_checksum (XOR of loaded words).
module inst_fetch_wide
  import inst_fetch_pkg::*;
#(
  parameter int INST_MEM_WIDTH = 10,
  parameter int FETCH_WIDTH    = 2
) (
  input  logic                                  CLK,
  input  logic                                  reset,
  input  logic [7:0]                            loader_data,
  input  logic                                  loader_valid,
  input  logic                                  loader_start,
  input  logic                                  loader_end,
  output logic                                  loader_ready,
  input  logic                                  stall,
  input  logic                                  redirect,
  input  logic [INST_MEM_WIDTH-1:0]             redirect_pc,
  output logic [FETCH_WIDTH-1:0][INST_BITS-1:0] inst,
  output logic [FETCH_WIDTH-1:0]                inst_valid,
  output logic [INST_MEM_WIDTH-1:0]             fetch_pc,
  output logic [INST_MEM_WIDTH-1:0]             pc_next,
  output logic                                  load_done,
`ifdef INST_FETCH_CHECKSUM_EN
  output logic                                  load_err,
  output logic [INST_BITS-1:0]                  load_checksum
`else
  output logic                                  load_err
`endif
);

  localparam int W     = INST_MEM_WIDTH;
  localparam int CW    = W + 1;
  localparam int DEPTH = 1 << W;

  state_e                                state_q, state_d;
  logic [CW-1:0]                         count_q, count_d;
  logic                                  err_q, err_d;
  logic                                  done_q, done_d;
  logic [FETCH_WIDTH-1:0][INST_BITS-1:0] inst_q, inst_d;
  logic [FETCH_WIDTH-1:0]                vld_q, vld_d;
  logic [W-1:0]                          fpc_q, fpc_d;
  logic [W-1:0]                          pcn_q, pcn_d;
  logic [INST_BITS-1:0]                  mem [DEPTH];

  logic                 full;
  logic                 ld_en;
  logic                 ld_valid;
  logic [INST_BITS-1:0] wr_word;
  logic                 wr_en;
  logic [W-1:0]         addr;

  assign full     = (count_q == CW'(DEPTH));
  assign ld_en    = (state_q == S_LOAD) && !loader_start;
  // bytes beyond a full memory are dropped before the packer
  assign ld_valid = loader_valid && !full;

  inst_loader_pack u_pack (
    .clk    (CLK),
    .rst    (reset),
    .clr_i  (loader_start),
    .en_i   (ld_en),
    .data_i (loader_data),
    .valid_i(ld_valid),
    .end_i  (loader_end),
    .word_o (wr_word),
    .we_o   (wr_en)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = done_q;
    inst_d  = inst_q;
    vld_d   = vld_q;
    fpc_d   = fpc_q;
    pcn_d   = pcn_q;
    addr    = '0;
    unique case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        if (loader_valid && full) err_d = 1'b1;
        if (wr_en) count_d = count_q + CW'(1);
        if (loader_end) begin
          state_d = S_RUN;
          done_d  = 1'b1;
          pcn_d   = '0;
        end
      end
      S_RUN: begin
        if (redirect) begin
          vld_d = '0;
          pcn_d = redirect_pc;
        end else if (!stall) begin
          for (int i = 0; i < FETCH_WIDTH; i++) begin
            addr      = pcn_q + W'(i);
            inst_d[i] = mem[addr];
            vld_d[i]  = ({1'b0, addr} < count_q);
          end
          fpc_d = pcn_q;
          pcn_d = pcn_q + W'(FETCH_WIDTH);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (loader_start) begin
      state_d = S_LOAD;
      count_d = '0;
      err_d   = 1'b0;
      done_d  = 1'b0;
      vld_d   = '0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      inst_q  <= '0;
      vld_q   <= '0;
      fpc_q   <= '0;
      pcn_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
      vld_q   <= vld_d;
      fpc_q   <= fpc_d;
      pcn_q   <= pcn_d;
    end
  end

  // memory contents survive reset
  always_ff @(posedge CLK) begin
    if (wr_en) mem[count_q[W-1:0]] <= wr_word;
  end

  assign loader_ready = (state_q != S_RUN);
  assign inst         = inst_q;
  assign inst_valid   = vld_q;
  assign fetch_pc     = fpc_q;
  assign pc_next      = pcn_q;
  assign load_done    = done_q;
  assign load_err     = err_q;

`ifdef INST_FETCH_CHECKSUM_EN
  logic [INST_BITS-1:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (wr_en) cks_d = cks_q ^ wr_word;
    if (loader_start) cks_d = '0;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) cks_q <= '0;
    else       cks_q <= cks_d;
  end

  assign load_checksum = cks_q;
`endif

endmodule

// File: tb/tb_inst_fetch_wide.sv
// Directed bench for inst_fetch_wide: two instances (1K-word and 4-word
// memories) driven by the same loader/fetch stimulus.
module tb_inst_fetch_wide;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] loader_data = '0;
  logic       loader_valid = 1'b0;
  logic       loader_start = 1'b0;
  logic       loader_end = 1'b0;
  logic       stall = 1'b0;
  logic       redirect = 1'b0;
  logic [9:0] rpc = '0;

  logic [1:0][31:0] inst0, inst1;
  logic [1:0]       vld0, vld1;
  logic [9:0]       fpc0, pcn0;
  logic [1:0]       fpc1, pcn1;
  logic             ready0, ready1, done0, done1, err0, err1;
`ifdef INST_FETCH_CHECKSUM_EN
  logic [31:0]      cks0, cks1;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  inst_fetch_wide #(.INST_MEM_WIDTH(10), .FETCH_WIDTH(2)) u0 (
    .CLK(CLK), .reset(reset),
    .loader_data(loader_data), .loader_valid(loader_valid),
    .loader_start(loader_start), .loader_end(loader_end),
    .loader_ready(ready0), .stall(stall), .redirect(redirect),
    .redirect_pc(rpc), .inst(inst0), .inst_valid(vld0),
    .fetch_pc(fpc0), .pc_next(pcn0), .load_done(done0),
`ifdef INST_FETCH_CHECKSUM_EN
    .load_err(err0), .load_checksum(cks0)
`else
    .load_err(err0)
`endif
  );

  inst_fetch_wide #(.INST_MEM_WIDTH(2), .FETCH_WIDTH(2)) u1 (
    .CLK(CLK), .reset(reset),
    .loader_data(loader_data), .loader_valid(loader_valid),
    .loader_start(loader_start), .loader_end(loader_end),
    .loader_ready(ready1), .stall(stall), .redirect(redirect),
    .redirect_pc(rpc[1:0]), .inst(inst1), .inst_valid(vld1),
    .fetch_pc(fpc1), .pc_next(pcn1), .load_done(done1),
`ifdef INST_FETCH_CHECKSUM_EN
    .load_err(err1), .load_checksum(cks1)
`else
    .load_err(err1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    loader_start = 1'b1;
    tick();
    loader_start = 1'b0;
  endtask

  task automatic do_end();
    loader_end = 1'b1;
    tick();
    loader_end = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    loader_data  = b;
    loader_valid = 1'b1;
    tick();
    loader_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_ready", ready0, 1);
    chk("rst_valid", vld0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_fpc", fpc0, 0);
    chk("rst_pcn", pcn0, 0);
    chk("rst_inst", inst0, 0);

    // 8-byte program, two full words
    do_start();
    send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    send(8'h44); send(8'h55); send(8'h66); send(8'h77);
    do_end();
    chk("t1_done", done0, 1);
    chk("t1_ready", ready0, 0);
    chk("t1_vld_entry", vld0, 0);
    chk("t1_pcn_entry", pcn0, 0);
    tick();
    chk("t1_inst", inst0, 64'h44556677_00112233);
    chk("t1_vld", vld0, 2'b11);
    chk("t1_fpc", fpc0, 0);
    chk("t1_pcn", pcn0, 2);
    tick();
    chk("t1_vld2", vld0, 2'b00);
    chk("t1_fpc2", fpc0, 2);
    chk("t1_pcn2", pcn0, 4);

    // reload with 5 bytes: last word zero padded
    do_start();
    chk("t2_done_clr", done0, 0);
    chk("t2_ready", ready0, 1);
    chk("t2_vld_clr", vld0, 0);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE);
    do_end();
    tick();
    chk("t2_inst", inst0, 64'hEE000000_AABBCCDD);
    chk("t2_vld", vld0, 2'b11);
    chk("t2_fpc", fpc0, 0);

    // stall freezes, redirect overrides stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_st_inst", inst0, 64'hEE000000_AABBCCDD);
      chk("t4_st_vld", vld0, 2'b11);
      chk("t4_st_fpc", fpc0, 0);
      chk("t4_st_pcn", pcn0, 2);
    end
    redirect = 1'b1;
    rpc = 10'd5;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    chk("t4_rd_vld", vld0, 2'b00);
    chk("t4_rd_pcn", pcn0, 5);
    tick();
    chk("t4_fpc", fpc0, 5);
    chk("t4_pcn", pcn0, 7);
    chk("t4_vld", vld0, 2'b00);

    // overflow of 4-word memory, unaligned wrapping fetch
    do_start();
    for (int k = 0; k < 20; k++) send(8'(k));
    chk("t3_err_small", err1, 1);
    chk("t3_err_big", err0, 0);
    do_end();
    redirect = 1'b1;
    rpc = 10'd3;
    tick();
    redirect = 1'b0;
    tick();
    chk("t3_inst_small", inst1, 64'h00010203_0C0D0E0F);
    chk("t3_vld_small", vld1, 2'b11);
    chk("t3_fpc_small", fpc1, 3);
    chk("t3_pcn_small", pcn1, 1);
    chk("t3_inst_big", inst0, 64'h10111213_0C0D0E0F);
    chk("t3_pcn_big", pcn0, 5);
    chk("t3_err_sticky", err1, 1);

    // async reset mid-load
    do_start();
    chk("t5_err_clr", err1, 0);
    send(8'hA0); send(8'hA1); send(8'hA2);
    send(8'hA3); send(8'hA4); send(8'hA5);
    #2 reset = 1'b1;
    #1;
    chk("t5_fpc", fpc0, 0);
    chk("t5_pcn", pcn0, 0);
    chk("t5_fpc_small", fpc1, 0);
    chk("t5_ready", ready0, 1);
    chk("t5_done", done0, 0);
    chk("t5_inst", inst0, 0);
    reset = 1'b0;
    tick();
    do_start();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    do_end();
    tick();
    chk("t5_lane0", inst0[0], 32'h01020304);
    chk("t5_vld", vld0, 2'b01);

    // empty program
    do_start();
    do_end();
    tick();
    chk("t7_done", done0, 1);
    chk("t7_vld", vld0, 2'b00);

`ifdef INST_FETCH_CHECKSUM_EN
    do_start();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    do_end();
    chk("t6_cks", cks0, 32'h444444CC);
    tick();
    chk("t6_cks_run", cks0, 32'h444444CC);
    do_start();
    chk("t6_cks_clr", cks0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
